// File: rtl/bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// bcd_updown_counter
//
// Multi-digit BCD up/down counter with a 7-segment decoder per digit. It is
// fully synchronous: the step input is a level signal and is turned into
// count events by an internal rising-edge detector. It sits between the
// debounced push-button/switch inputs and the HEX display bank.
//
// Parameters
//   DIGITS    number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
//   SATURATE  0 = wrap around at the limits, 1 = hold at the limits
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous, active-low reset (0 = reset); highest priority
//   step        count request (level); one count per 0->1 transition
//   up_down     1 = count up, 0 = count down
//   load        synchronous parallel load of load_value (beats step)
//   load_value  BCD load value, digit 0 in [3:0]; digits above 9 load as 0
//   bcd_out     registered count in BCD, digit 0 in [3:0]
//   seg_out     active-low segments, digit k in [7k+6:7k], bit 6 = a .. bit 0 = g
//   wrap        one-cycle pulse after an overflow or underflow wrap
//   at_limit    combinational: count at max when counting up, at 0 when down
//
// Optional feature
//   BCD_LEADING_ZERO_BLANK_EN  when defined, zero digits above the most
//                              significant non-zero digit are blanked on
//                              seg_out. Digit 0 always shows its value.
//                              bcd_out is not affected.
// -----------------------------------------------------------------------------
module bcd_updown_counter #(
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out,
  output logic                  wrap,
  output logic                  at_limit
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low a..g pattern for one BCD digit; non-BCD codes blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_d;
  logic                step_q;
  logic                armed_q;
  logic                wrap_d;

  // Step edge detection. step_q follows step; armed_q stays low after reset
  // while step is held high, so a button already pressed when reset releases
  // has to be released and pressed again before it counts.
  logic ev;
  assign ev = step & ~step_q & armed_q;

  // ---------------------------------------------------------------------------
  // Increment / decrement of the whole BCD word in a single cycle. The carry
  // and borrow are resolved across all digits combinationally, so every digit
  // updates on the same edge.
  // ---------------------------------------------------------------------------
  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic                all_nine;
  logic                all_zero;

  always_comb begin : arith
    logic       carry;
    logic       borrow;
    logic [3:0] digit;
    // NOTE: every variable assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    inc_val  = count_q;
    dec_val  = count_q;
    all_nine = 1'b1;
    all_zero = 1'b1;
    carry    = 1'b1;
    borrow   = 1'b1;
    digit    = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = count_q[4*k +: 4];
      if (digit != 4'd9) all_nine = 1'b0;
      if (digit != 4'd0) all_zero = 1'b0;

      if (carry) begin
        if (digit >= 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = digit + 4'd1;
          carry             = 1'b0;
        end
      end

      if (borrow) begin
        if (digit == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = digit - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  // Load value with any non-BCD digit replaced by 0.
  logic [4*DIGITS-1:0] load_clean;

  always_comb begin : sanitise
    load_clean = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_value[4*k +: 4] <= 4'd9) begin
        load_clean[4*k +: 4] = load_value[4*k +: 4];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next count: load beats a step event, which beats hold. A wrap only happens
  // in wrap mode; in saturate mode the count simply stays at the limit.
  // ---------------------------------------------------------------------------
  always_comb begin : next_count
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = load_clean;
    end else if (ev) begin
      if (up_down) begin
        if (!(all_nine && SATURATE != 0)) begin
          count_d = inc_val;
          wrap_d  = all_nine;
        end
      end else begin
        if (!(all_zero && SATURATE != 0)) begin
          count_d = dec_val;
          wrap_d  = all_zero;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset is synchronous and overrides load and step.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      count_q <= '0;
      step_q  <= 1'b0;
      armed_q <= ~step;
      wrap    <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step;
      armed_q <= armed_q | ~step;
      wrap    <= wrap_d;
    end
  end

  assign bcd_out  = count_q;
  assign at_limit = up_down ? all_nine : all_zero;

  // ---------------------------------------------------------------------------
  // Segment decode of the registered count (no extra latency).
  // ---------------------------------------------------------------------------
`ifdef BCD_LEADING_ZERO_BLANK_EN
  always_comb begin : seg_decode_blank
    logic       nz_seen;
    logic [3:0] digit;
    seg_out = {(7*DIGITS){1'b1}};
    nz_seen = 1'b0;
    digit   = 4'd0;
    // Walk from the most significant digit down; digits are blanked until the
    // first non-zero one is seen. Digit 0 is never blanked.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      digit = count_q[4*k +: 4];
      if (digit != 4'd0) nz_seen = 1'b1;
      if (!nz_seen && k != 0) begin
        seg_out[7*k +: 7] = SEG_BLANK;
      end else begin
        seg_out[7*k +: 7] = seg_decode(digit);
      end
    end
  end
`else
  always_comb begin : seg_decode_all
    seg_out = {(7*DIGITS){1'b1}};
    for (int k = 0; k < DIGITS; k++) begin
      seg_out[7*k +: 7] = seg_decode(count_q[4*k +: 4]);
    end
  end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_updown_counter
//
// Scoreboard bench for bcd_updown_counter. Instance 0 is DIGITS=2 wrapping,
// instance 1 is DIGITS=2 saturating. The stimulus thread pushes the expected
// register state for a given cycle into a queue; a monitor on the falling
// edge pops every entry due in that cycle and compares it with the outputs.
// -----------------------------------------------------------------------------
module tb_bcd_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance stimulus and response (index 0 = wrap, 1 = saturate).
  logic       rst_v  [2];
  logic       step_v [2];
  logic       ud_v   [2];
  logic       ld_v   [2];
  logic [7:0] lv_v   [2];
  logic [7:0] bcd_o  [2];
  logic [13:0] seg_o [2];
  logic       wrap_o [2];
  logic       lim_o  [2];

  bcd_updown_counter #(.DIGITS(2), .SATURATE(0)) dut_wrap (
    .clk        (clk),
    .reset      (rst_v[0]),
    .step       (step_v[0]),
    .up_down    (ud_v[0]),
    .load       (ld_v[0]),
    .load_value (lv_v[0]),
    .bcd_out    (bcd_o[0]),
    .seg_out    (seg_o[0]),
    .wrap       (wrap_o[0]),
    .at_limit   (lim_o[0])
  );

  bcd_updown_counter #(.DIGITS(2), .SATURATE(1)) dut_sat (
    .clk        (clk),
    .reset      (rst_v[1]),
    .step       (step_v[1]),
    .up_down    (ud_v[1]),
    .load       (ld_v[1]),
    .load_value (lv_v[1]),
    .bcd_out    (bcd_o[1]),
    .seg_out    (seg_o[1]),
    .wrap       (wrap_o[1]),
    .at_limit   (lim_o[1])
  );

  // High-digit pattern expected when the tens digit is zero.
`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] HI_ZERO = 7'b1111111;
`else
  localparam logic [6:0] HI_ZERO = 7'b0000001;
`endif

  typedef struct {
    int          inst;
    int          cyc;
    string       nm;
    logic [7:0]  bcd;
    logic        wrap;
    logic [13:0] seg;
  } exp_t;

  exp_t sb[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc++;

  // Hand-written digit table.
  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0000001;
      4'd1: return 7'b1001111;
      4'd2: return 7'b0010010;
      4'd3: return 7'b0000110;
      4'd4: return 7'b1001100;
      4'd5: return 7'b0100100;
      4'd6: return 7'b0100000;
      4'd7: return 7'b0001111;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [13:0] seg_model(input logic [7:0] b);
    logic [6:0] hi;
    hi = (b[7:4] == 4'd0) ? HI_ZERO : dec7(b[7:4]);
    return {hi, dec7(b[3:0])};
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input int c, input string nm,
                      input logic [7:0] b, input logic w, input logic [13:0] s);
    exp_t e;
    e.inst = i; e.cyc = c; e.nm = nm; e.bcd = b; e.wrap = w; e.seg = s;
    sb.push_back(e);
  endtask

  // One step pulse (high 1 cycle, low 2 cycles). Expects the new count with
  // the given wrap flag, then the same count with wrap cleared.
  task automatic pulse(input int i, input logic ud, input logic [7:0] b,
                       input logic w, input string nm);
    ud_v[i]   = ud;
    step_v[i] = 1'b1;
    push(i, cyc + 1, nm, b, w, seg_model(b));
    tick();
    step_v[i] = 1'b0;
    push(i, cyc + 1, {nm, "_after"}, b, 1'b0, seg_model(b));
    tick();
    tick();
  endtask

  task automatic do_reset(input int i);
    rst_v[i] = 1'b0; step_v[i] = 1'b0; ld_v[i] = 1'b0; ud_v[i] = 1'b0;
    tick();
    tick();
    push(i, cyc, "reset", 8'h00, 1'b0, {HI_ZERO, 7'b0000001});
    rst_v[i] = 1'b1;
    tick();
  endtask

  task automatic do_load(input int i, input logic [7:0] v, input logic [7:0] b,
                         input string nm);
    ld_v[i] = 1'b1;
    lv_v[i] = v;
    push(i, cyc + 1, nm, b, 1'b0, seg_model(b));
    tick();
    ld_v[i] = 1'b0;
  endtask

  // Monitor: compares every scoreboard entry due in the current cycle.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() != 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s: sample missed, due cycle %0d, now %0d", e.nm, e.cyc, cyc);
      end else begin
        check({e.nm, "/bcd"},  32'(bcd_o[e.inst]),  32'(e.bcd));
        check({e.nm, "/wrap"}, 32'(wrap_o[e.inst]), 32'(e.wrap));
        check({e.nm, "/seg"},  32'(seg_o[e.inst]),  32'(e.seg));
        check({e.nm, "/lim"},  32'(lim_o[e.inst]),
              32'(ud_v[e.inst] ? (e.bcd == 8'h99) : (e.bcd == 8'h00)));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b0; step_v[i] = 1'b0; ud_v[i] = 1'b0;
      ld_v[i] = 1'b0;  lv_v[i] = 8'h00;
    end
    tick();

    // ---------------- Instance 0: wrap mode ----------------
    do_reset(0);

    // Count up to 11 with separate pulses, then the 12th pulse is held high.
    for (int n = 1; n <= 11; n++) pulse(0, 1'b1, to_bcd(n), 1'b0, "up");
    step_v[0] = 1'b1;
    for (int j = 0; j < 10; j++) begin
      push(0, cyc + 1, "hold12", 8'h12, 1'b0, {7'b1001111, 7'b0010010});
      tick();
    end
    step_v[0] = 1'b0;

    // Wrap at both limits.
    do_load(0, 8'h99, 8'h99, "load99");
    pulse(0, 1'b1, 8'h00, 1'b1, "up_wrap");
    pulse(0, 1'b0, 8'h99, 1'b1, "dn_wrap");
    pulse(0, 1'b0, 8'h98, 1'b0, "dn");

    // Carry and borrow between digits.
    do_load(0, 8'h09, 8'h09, "load09");
    pulse(0, 1'b1, 8'h10, 1'b0, "carry");
    pulse(0, 1'b0, 8'h09, 1'b0, "borrow");

    // Load with a non-BCD digit and a simultaneous step edge.
    step_v[0] = 1'b1;
    do_load(0, 8'h5C, 8'h50, "load5C");
    push(0, cyc + 1, "load_ate_edge", 8'h50, 1'b0, seg_model(8'h50));
    tick();

    // Reset during a step edge; step stays high across release.
    step_v[0] = 1'b0;
    tick();
    step_v[0] = 1'b1;
    rst_v[0]  = 1'b0;
    push(0, cyc + 1, "rst_on_edge", 8'h00, 1'b0, {HI_ZERO, 7'b0000001});
    tick();
    rst_v[0] = 1'b1;
    push(0, cyc + 1, "held_release", 8'h00, 1'b0, {HI_ZERO, 7'b0000001});
    tick();
    push(0, cyc + 1, "held_release2", 8'h00, 1'b0, {HI_ZERO, 7'b0000001});
    tick();
    step_v[0] = 1'b0;
    tick();
    pulse(0, 1'b1, 8'h01, 1'b0, "first_after_rst");

    // Leading-digit display.
    ld_v[0] = 1'b1;
    lv_v[0] = 8'h07;
    push(0, cyc + 1, "seg07", 8'h07, 1'b0, {HI_ZERO, 7'b0001111});
    tick();
    lv_v[0] = 8'h00;
    push(0, cyc + 1, "seg00", 8'h00, 1'b0, {HI_ZERO, 7'b0000001});
    tick();
    ld_v[0] = 1'b0;

    // ---------------- Instance 1: saturate mode ----------------
    do_reset(1);
    ud_v[1] = 1'b0;
    do_load(1, 8'h00, 8'h00, "sat_load00");
    for (int n = 0; n < 3; n++) pulse(1, 1'b0, 8'h00, 1'b0, "sat_dn_hold");
    ud_v[1] = 1'b1;
    do_load(1, 8'h98, 8'h98, "sat_load98");
    pulse(1, 1'b1, 8'h99, 1'b0, "sat_up_to_max");
    pulse(1, 1'b1, 8'h99, 1'b0, "sat_up_hold");
    do_load(1, 8'h99, 8'h99, "sat_load99");
    pulse(1, 1'b1, 8'h99, 1'b0, "sat_up_hold2");
    pulse(1, 1'b0, 8'h98, 1'b0, "sat_dn");

    repeat (3) tick();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Parametrised, fully synchronous multi-digit BCD up/down counter with built-in 7-segment decode per digit.
- Successor to the single-digit ripple down-counter display block. Adds:
  - single clock domain with a step input and internal rising-edge detection, so no button-as-clock;
  - configurable digit count, direction control, parallel load, and wrap or saturate at the limits.
- Sits between the debounced board push-button/switch inputs and the HEX display bank.

Parameters:
- DIGITS, 2: number of BCD digits, 1..8. Count range is 0 .. 10^DIGITS-1.
- SATURATE, 0: 0 = wrap at limits; 1 = hold at limits.

Ports:
- clk, input, 1: system clock. All state updates on the rising edge.
- reset, input, 1: synchronous, active-low reset. Sampled on clk rising edge; 0 = reset.
- step, input, 1: count request, level signal. One count per 0->1 transition seen at clk.
- up_down, input, 1: 1 = count up, 0 = count down. Sampled in the same cycle as the step edge.
- load, input, 1: synchronous parallel load of load_value.
- load_value, input, 4*DIGITS: BCD value; digit 0 in bits [3:0].
- bcd_out, output, 4*DIGITS: current count in BCD; digit 0 in bits [3:0].
- seg_out, output, 7*DIGITS: active-low segments per digit.
  - Digit k occupies [7k+6:7k].
  - Within each field, bit 6 = segment a ... bit 0 = segment g, so a field drives a [0:6] HEX port directly.
- wrap, output, 1: one-cycle pulse on overflow (up from max) or underflow (down from 0).
- at_limit, output, 1: high while count == 0 when up_down=0, or count == max when up_down=1. Combinational.

Behaviour:
- Reset (reset=0 at clk edge):
  - count = 0 (all digits), edge register step_q = 0, wrap = 0.
  - Reset has priority over everything.
  - seg_out shows "0" on every digit: 7'b0000001 per field.
- Edge detect:
  - step_q <= step every cycle.
  - Event ev = step & ~step_q.
  - A step held high yields exactly one event.
  - A step already high when reset releases yields no event until it goes low and high again.
- Priority per cycle, highest first: reset > load > ev > hold.
- Load:
  - count <= load_value in the next cycle. wrap = 0.
  - Any load digit > 9 is loaded as 0 (per-digit sanitising).
  - A step edge in the same cycle is consumed and ignored.
- Count up on ev:
  - Digit 0 increments. A digit going 9->0 carries into the next digit, ripple-free, all within one cycle.
  - At max (all 9s):
    - SATURATE=0: count -> 0 and wrap=1 for one cycle.
    - SATURATE=1: count holds and wrap stays 0.
- Count down on ev:
  - Digit 0 decrements. A digit going 0->9 borrows from the next digit.
  - At 0:
    - SATURATE=0: count -> all 9s and wrap=1.
    - SATURATE=1: count holds and wrap stays 0.
- Latency: bcd_out and wrap change on the clk edge after the cycle in which ev or load is sampled. seg_out is a combinational decode of the registered count (no extra cycle).
- wrap is registered. It is 0 in every cycle that is not the single cycle following a wrap event.
- Decode (a..g, active-low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Any other value: 1111111 (blank; unreachable in normal operation).
- Reset asserted mid-count: takes effect at that clk edge regardless of load or step. wrap is forced to 0.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - Zero digits above the most significant non-zero digit show 1111111 (blank).
  - Digit 0 always shows its value, so a count of 0 shows a single "0".
  - bcd_out is unaffected.
- Undefined: every digit is always decoded, leading zeros included.

Test Plan:
- DIGITS=2, SATURATE=0; reset=0 for 2 cycles then 1 -> bcd_out=8'h00, each seg_out field 0000001, wrap=0.
- Up from 00; 12 step pulses (low 2 cycles between pulses) -> bcd_out=8'h12, seg_out={1001111,0010010}. Hold step high 10 cycles -> count stays 12.
- load=1, load_value=8'h99, then one up step -> bcd_out=8'h00 and wrap=1 for exactly one cycle. Down step -> 8'h99 with wrap=1 for one cycle. Down step again -> 8'h98, wrap=0.
- SATURATE=1; load 8'h00, up_down=0, 3 steps -> stays 8'h00, wrap never 1, at_limit=1. Load 8'h99 with up_down=1, step -> stays 8'h99.
- load_value=8'h5C with load=1 and a step edge in the same cycle -> bcd_out=8'h50, no count applied. Then reset=0 during a step edge -> 8'h00.
- With BCD_LEADING_ZERO_BLANK_EN defined, count 8'h07 -> high field 1111111, low field 0001111. Count 8'h00 -> high field blank, low field 0000001.
